// File: rtl/noc_buf_pkg.sv
// Shared types and helpers for the NoC virtual-channel input buffer.
package noc_buf_pkg;

  localparam int DATA_W_DEF = 16;

  typedef logic [DATA_W_DEF-1:0] flit_t;

  // Width of a VC index; a single-VC buffer still carries a 1-bit index.
  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// One virtual-channel FIFO: circular storage, wrapping pointers and an
// occupancy count. Push/pop are already qualified by the caller; flush wins.
module noc_vc_fifo import noc_buf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Storage is not reset; only accepted, non-flushed pushes write.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush returns the VC to empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Router input buffer: NUM_VC independent FIFOs, one write and one pop per
// cycle, registered pop data with a one-hot credit back to upstream.
module noc_vc_input_buffer import noc_buf_pkg::*; #(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 4,
  parameter  int NUM_VC = 2,
  localparam int VC_W   = vc_w(NUM_VC)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              buf_write_i,
  input  logic [VC_W-1:0]   buf_wr_vc_i,
  input  logic [DATA_W-1:0] buf_data_i,
  input  logic              buf_read_i,
  input  logic [VC_W-1:0]   buf_rd_vc_i,
  input  logic [NUM_VC-1:0] buf_flush_i,
  output logic [NUM_VC-1:0] buf_empty_o,
  output logic [NUM_VC-1:0] buf_full_o,
  output logic              buf_valid_o,
  output logic [DATA_W-1:0] buf_data_o,
  output logic [VC_W-1:0]   buf_vc_o,
  output logic [NUM_VC-1:0] buf_credit_o,
  output logic              buf_overflow_o
);

  logic [NUM_VC-1:0]             wr_hit, rd_hit, push, pop, drop;
  logic [NUM_VC-1:0][DATA_W-1:0] head;
  logic [DATA_W-1:0]             head_sel;
  logic                          ovf_nxt;

  // Decode requests per VC. A pop needs a non-empty VC at the start of the
  // cycle (no bypass); a write to a full VC survives only alongside a pop.
  // An out-of-range write index matches no VC and counts as dropped.
  always_comb begin
    wr_hit   = '0;
    rd_hit   = '0;
    push     = '0;
    pop      = '0;
    drop     = '0;
    head_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = buf_write_i && (buf_wr_vc_i == VC_W'(v));
      rd_hit[v] = buf_read_i  && (buf_rd_vc_i == VC_W'(v));
      pop[v]    = rd_hit[v] && !buf_empty_o[v] && !buf_flush_i[v];
      push[v]   = wr_hit[v] && !buf_flush_i[v] && (!buf_full_o[v] || pop[v]);
      drop[v]   = wr_hit[v] && !buf_flush_i[v] && buf_full_o[v] && !pop[v];
      head_sel  = head_sel | (head[v] & {DATA_W{pop[v]}});
    end
    ovf_nxt = (|drop) || (buf_write_i && !(|wr_hit));
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    noc_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .flush (buf_flush_i[v]),
      .din   (buf_data_i),
      .head  (head[v]),
      .empty (buf_empty_o[v]),
      .full  (buf_full_o[v])
    );
  end

  // Output stage: one-cycle pop latency; data and VC hold between pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_o    <= 1'b0;
      buf_data_o     <= '0;
      buf_vc_o       <= '0;
      buf_credit_o   <= '0;
      buf_overflow_o <= 1'b0;
    end else begin
      buf_valid_o    <= |pop;
      buf_credit_o   <= pop;
      buf_overflow_o <= ovf_nxt;
      if (|pop) begin
        buf_data_o <= head_sel;
        buf_vc_o   <= buf_rd_vc_i;
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench for noc_vc_input_buffer with a queue-based reference model.
module tb_noc_vc_input_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              buf_write_i, buf_read_i;
  logic [VC_W-1:0]   buf_wr_vc_i, buf_rd_vc_i;
  logic [DATA_W-1:0] buf_data_i;
  logic [NUM_VC-1:0] buf_flush_i;
  logic [NUM_VC-1:0] buf_empty_o, buf_full_o, buf_credit_o;
  logic              buf_valid_o, buf_overflow_o;
  logic [DATA_W-1:0] buf_data_o;
  logic [VC_W-1:0]   buf_vc_o;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [DATA_W-1:0] mq [NUM_VC][$];
  logic              e_valid, e_ovf;
  logic [DATA_W-1:0] e_data;
  int                e_vc;
  logic [NUM_VC-1:0] e_credit;

  noc_vc_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk(clk), .reset(reset),
    .buf_write_i(buf_write_i), .buf_wr_vc_i(buf_wr_vc_i), .buf_data_i(buf_data_i),
    .buf_read_i(buf_read_i), .buf_rd_vc_i(buf_rd_vc_i), .buf_flush_i(buf_flush_i),
    .buf_empty_o(buf_empty_o), .buf_full_o(buf_full_o), .buf_valid_o(buf_valid_o),
    .buf_data_o(buf_data_o), .buf_vc_o(buf_vc_o), .buf_credit_o(buf_credit_o),
    .buf_overflow_o(buf_overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    e_valid = 0; e_ovf = 0; e_data = '0; e_vc = 0; e_credit = '0;
  endtask

  // One clock of the behavioural rules: pop before push, flush last.
  task automatic model_step(input bit w, input int wv, input logic [DATA_W-1:0] d,
                            input bit r, input int rv, input logic [NUM_VC-1:0] fl);
    bit rd_ok, wr_ok;
    e_valid = 0; e_credit = '0; e_ovf = 0;
    rd_ok = r && rv < NUM_VC && mq[rv].size() > 0 && !fl[rv];
    wr_ok = 0;
    if (w) begin
      if (wv >= NUM_VC) e_ovf = 1;
      else if (!fl[wv]) begin
        if (mq[wv].size() < DEPTH || (rd_ok && rv == wv)) wr_ok = 1;
        else e_ovf = 1;
      end
    end
    if (rd_ok) begin
      e_data = mq[rv].pop_front();
      e_vc = rv; e_valid = 1; e_credit[rv] = 1'b1;
    end
    if (wr_ok) mq[wv].push_back(d);
    for (int v = 0; v < NUM_VC; v++) if (fl[v]) mq[v].delete();
  endtask

  // Compare DUT against model every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      logic [NUM_VC-1:0] em, fu;
      for (int v = 0; v < NUM_VC; v++) begin
        em[v] = (mq[v].size() == 0);
        fu[v] = (mq[v].size() == DEPTH);
      end
      chk("m_empty", 32'(buf_empty_o), 32'(em));
      chk("m_full", 32'(buf_full_o), 32'(fu));
      chk("m_valid", 32'(buf_valid_o), 32'(e_valid));
      chk("m_credit", 32'(buf_credit_o), 32'(e_credit));
      chk("m_ovf", 32'(buf_overflow_o), 32'(e_ovf));
      chk("m_data", 32'(buf_data_o), 32'(e_data));
      if (e_valid) chk("m_vc", 32'(buf_vc_o), 32'(e_vc));
    end
  end

  task automatic step(input bit w, input int wv, input logic [DATA_W-1:0] d,
                      input bit r, input int rv, input logic [NUM_VC-1:0] fl);
    buf_write_i = w; buf_wr_vc_i = VC_W'(wv); buf_data_i = d;
    buf_read_i = r; buf_rd_vc_i = VC_W'(rv); buf_flush_i = fl;
    @(posedge clk);
    model_step(w, wv, d, r, rv, fl);
    @(negedge clk);
    #1;
    buf_write_i = 0; buf_read_i = 0; buf_flush_i = '0;
  endtask

  task automatic wr(input int v, input logic [DATA_W-1:0] d);
    step(1, v, d, 0, 0, '0);
  endtask

  task automatic rd(input int v);
    step(0, 0, '0, 1, v, '0);
  endtask

  initial begin
    reset = 1; buf_write_i = 0; buf_read_i = 0; buf_wr_vc_i = '0;
    buf_rd_vc_i = '0; buf_data_i = '0; buf_flush_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0; #1;
    chk("rst_empty", 32'(buf_empty_o), 32'h3);
    chk("rst_full", 32'(buf_full_o), 32'h0);
    chk("rst_valid", 32'(buf_valid_o), 32'h0);

    // 1: fill VC1, then overflow
    for (int i = 1; i <= 4; i++) wr(1, 16'hA000 + 16'(i));
    chk("t1_full", 32'(buf_full_o), 32'h2);
    chk("t1_empty", 32'(buf_empty_o), 32'h1);
    wr(1, 16'hA005);
    chk("t1_ovf", 32'(buf_overflow_o), 32'h1);
    step(0, 0, '0, 0, 0, '0);
    chk("t1_ovf_end", 32'(buf_overflow_o), 32'h0);

    // 2: drain VC1 back-to-back
    for (int i = 1; i <= 4; i++) begin
      rd(1);
      chk("t2_valid", 32'(buf_valid_o), 32'h1);
      chk("t2_data", 32'(buf_data_o), 32'hA000 + i);
      chk("t2_vc", 32'(buf_vc_o), 32'h1);
      chk("t2_credit", 32'(buf_credit_o), 32'h2);
    end
    chk("t2_empty", 32'(buf_empty_o), 32'h3);

    // 3: full VC0 with simultaneous write and pop, wrap
    for (int i = 1; i <= 4; i++) wr(0, 16'hB000 + 16'(i));
    step(1, 0, 16'hB005, 1, 0, '0);
    chk("t3_ovf", 32'(buf_overflow_o), 32'h0);
    chk("t3_data", 32'(buf_data_o), 32'hB001);
    chk("t3_full", 32'(buf_full_o), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      rd(0);
      chk("t3_pop", 32'(buf_data_o), 32'hB000 + i);
    end

    // 4: empty VC0, same-cycle write and pop: no bypass
    step(1, 0, 16'hC001, 1, 0, '0);
    chk("t4_valid", 32'(buf_valid_o), 32'h0);
    chk("t4_credit", 32'(buf_credit_o), 32'h0);
    chk("t4_hold", 32'(buf_data_o), 32'hB005);
    rd(0);
    chk("t4_data", 32'(buf_data_o), 32'hC001);

    // 5: flush VC0 with a same-cycle pop; VC1 untouched
    for (int i = 1; i <= 3; i++) wr(0, 16'hD000 + 16'(i));
    wr(1, 16'hD101);
    step(0, 0, '0, 1, 0, 2'b01);
    chk("t5_valid", 32'(buf_valid_o), 32'h0);
    chk("t5_credit", 32'(buf_credit_o), 32'h0);
    chk("t5_empty", 32'(buf_empty_o), 32'h1);
    rd(1);
    chk("t5_vc1", 32'(buf_data_o), 32'hD101);

    // 6: asynchronous reset mid-cycle with data stored and valid high
    wr(0, 16'hE001);
    wr(0, 16'hE002);
    rd(0);
    chk("t6_pre_valid", 32'(buf_valid_o), 32'h1);
    #2 reset = 1;
    #1;
    chk("t6_valid", 32'(buf_valid_o), 32'h0);
    chk("t6_data", 32'(buf_data_o), 32'h0);
    chk("t6_credit", 32'(buf_credit_o), 32'h0);
    chk("t6_empty", 32'(buf_empty_o), 32'h3);
    chk("t6_full", 32'(buf_full_o), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk); reset = 0; #1;
    rd(0);
    chk("t6_post_valid", 32'(buf_valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/noc_vc_input_buffer.md
Name: noc_vc_input_buffer

Overview:
Parametrised router input buffer that holds flits in NUM_VC independent virtual-channel FIFOs of DEPTH entries each. The upstream link writes tagged flits. The switch allocator pops one flit per cycle from a selected VC. Each pop returns a one-hot credit to the upstream router. It adds per-VC full/empty flags, overflow reporting and per-VC flush over the single-queue 16-bit buffer.

Parameters:
DATA_W, 16, flit width in bits
DEPTH, 4, entries per VC (>=2, need not be a power of 2)
NUM_VC, 2, number of virtual channels (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
buf_write_i  input  1  write request from upstream link
buf_wr_vc_i  input  VC_W  target VC of write (VC_W = max(1,$clog2(NUM_VC)))
buf_data_i  input  DATA_W  flit to write
buf_read_i  input  1  pop request from switch allocator
buf_rd_vc_i  input  VC_W  VC to pop
buf_flush_i  input  NUM_VC  per-VC synchronous clear
buf_empty_o  output  NUM_VC  per-VC empty flag
buf_full_o  output  NUM_VC  per-VC full flag
buf_valid_o  output  1  buf_data_o/buf_vc_o valid this cycle
buf_data_o  output  DATA_W  popped flit
buf_vc_o  output  VC_W  VC the popped flit came from
buf_credit_o  output  NUM_VC  one-hot credit pulse, one per popped flit
buf_overflow_o  output  1  one-cycle pulse: write to full VC dropped

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - all counts and pointers 0
  - buf_valid_o, buf_data_o, buf_vc_o, buf_credit_o, buf_overflow_o = 0
  - buf_empty_o all 1s; buf_full_o all 0s
  - stored data is don't-care
- Per-VC state:
  - wr_ptr, rd_ptr in 0..DEPTH-1; each wraps DEPTH-1 -> 0
  - count in 0..DEPTH, width $clog2(DEPTH+1)
  - empty = (count==0), full = (count==DEPTH); both combinational from registered count
- Write:
  - accepted iff buf_write_i and target VC not full, or target VC full and popped in the same cycle
  - accepted write stores buf_data_i at wr_ptr; wr_ptr advances
  - rejected write: data dropped, state unchanged, buf_overflow_o=1 next cycle
  - buf_wr_vc_i >= NUM_VC is treated as rejected (overflow pulse)
- Read:
  - successful iff buf_read_i, buf_rd_vc_i < NUM_VC, and that VC's count>0 at the start of the cycle
  - no same-cycle bypass: a write into an empty VC is not readable until the next cycle
  - latency 1: the cycle after a successful pop, buf_valid_o=1, buf_data_o=head flit, buf_vc_o=VC, buf_credit_o[VC]=1 (all other bits 0)
  - unsuccessful read: next cycle buf_valid_o=0 and buf_credit_o=0; buf_data_o holds its last value
- Simultaneous write+read, same VC:
  - count unchanged; both pointers advance
  - if full: both succeed, no overflow
  - if empty: write stored, read fails
- Different VCs: write and read are fully independent.
- Flush:
  - buf_flush_i[v]=1 sets count/pointers of VC v to 0 at the next edge
  - flush overrides a same-cycle write or pop on v: no credit, no valid, no overflow for v
  - flushed entries return no credits; upstream resynchronises credits on flush
- Count update per VC: count + wr_acc - rd_ok, no wrap; the acceptance rules guarantee the range.

Decomposition:
- Package noc_buf_pkg:
  - DATA_W_DEF
  - typedef flit_t (logic [DATA_W-1:0])
  - function vc_w(n) returning max(1,$clog2(n))
- Sub-module noc_vc_fifo (one per VC, generate loop):
  - inputs: push, pop, flush, din
  - outputs: head data, empty, full
  - contains pointers and count
- Top level holds:
  - write/read decode to per-VC push/pop
  - output registers
  - credit one-hot encoding
  - overflow pulse

Test Plan:
1. NUM_VC=2, DEPTH=4: write 0xA001..0xA004 to VC1 -> buf_full_o=2'b10, buf_empty_o=2'b01; 5th write 0xA005 -> buf_overflow_o pulses 1 cycle, data lost.
2. Pop VC1 four times back-to-back -> buf_valid_o high 4 consecutive cycles, data 0xA001..0xA004 in order, buf_vc_o=1, buf_credit_o=2'b10 each cycle; then buf_empty_o=2'b11.
3. Full VC0 plus same-cycle write 0xB005 and pop -> no overflow, count stays 4; subsequent pops return old entries 2..4 then 0xB005 (wrap verified).
4. Empty VC0, same-cycle write 0xC001 and pop VC0 -> next cycle buf_valid_o=0, credit 0; pop on following cycle returns 0xC001.
5. VC0 holding 3 flits, buf_flush_i=2'b01 with a same-cycle pop of VC0 -> no valid/credit, buf_empty_o[0]=1; VC1 contents untouched.
6. Assert reset asynchronously between clock edges while flits are stored and buf_valid_o=1 -> all outputs to reset values immediately; after release, pop returns buf_valid_o=0.
